// File: rtl/mem_pipe_ctrl.sv
// mem_pipe_ctrl: back-end pipeline control for EX -> MEM0 -> MEM -> WB.
//
// Generates load-enable/clear strobes for the EX/MEM0, MEM0/MEM and MEM/WB
// pipeline registers, tracks a valid bit per stage, runs the dcache miss
// stall FSM (IDLE -> MISS_WAIT -> REPLAY -> IDLE) and converts a MEM-stage
// exception/refetch into a full back-end flush plus a one-cycle redirect.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   ex_valid          EX holds a valid instruction ready for MEM0
//   mem_unhit         MEM-stage instruction missed in dcache
//   mem_exception     MEM-stage instruction carries an exception
//   mem_refetch       MEM-stage instruction requests refetch
//   refill_done       dcache refill complete (one-cycle pulse)
//   mem0_wr/_flush    EX/MEM0 register load / clear
//   mem_wr/_flush     MEM0/MEM register load / clear
//   wb_wr/_flush      MEM/WB register load / clear
//   ex_allowin        EX may hand off this cycle
//   redirect          one-cycle front-end refetch/handler pulse
//   mem0_valid, mem_valid, wb_valid   stage valid bits
//   busy              FSM not in IDLE
//   miss_stall_cnt    saturating count of miss-stall cycles
module mem_pipe_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic             mem_unhit,
  input  logic             mem_exception,
  input  logic             mem_refetch,
  input  logic             refill_done,
  output logic             mem0_wr,
  output logic             mem0_flush,
  output logic             mem_wr,
  output logic             mem_flush,
  output logic             wb_wr,
  output logic             wb_flush,
  output logic             ex_allowin,
  output logic             redirect,
  output logic             mem0_valid,
  output logic             mem_valid,
  output logic             wb_valid,
  output logic             busy,
  output logic [CNT_W-1:0] miss_stall_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    MISS_WAIT,
    REPLAY
  } state_t;

  state_t state, state_nxt;
  logic   excp, miss_det, stall;

  // Exceptions win over misses, and both are only recognised in IDLE:
  // in REPLAY the line is resident, so mem_unhit is stale.
  always_comb begin
    excp     = mem_valid & (mem_exception | mem_refetch) & (state == IDLE);
    miss_det = mem_valid & mem_unhit & ~excp & (state == IDLE);
    stall    = miss_det | (state == MISS_WAIT);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (miss_det)    state_nxt = MISS_WAIT;
      MISS_WAIT: if (refill_done) state_nxt = REPLAY;
      REPLAY:                     state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Pipeline register strobes; flush and wr are never both set.
  always_comb begin
    mem0_wr    = 1'b1;
    mem0_flush = 1'b0;
    mem_wr     = 1'b1;
    mem_flush  = 1'b0;
    wb_wr      = 1'b1;
    wb_flush   = 1'b0;
    ex_allowin = 1'b1;
    redirect   = 1'b0;
    if (reset) begin
      mem0_wr    = 1'b0;
      mem_wr     = 1'b0;
      wb_wr      = 1'b0;
      mem0_flush = 1'b1;
      mem_flush  = 1'b1;
      wb_flush   = 1'b1;
      ex_allowin = 1'b0;
    end else if (excp) begin
      mem0_wr    = 1'b0;
      mem_wr     = 1'b0;
      wb_wr      = 1'b0;
      mem0_flush = 1'b1;
      mem_flush  = 1'b1;
      wb_flush   = 1'b1;
      ex_allowin = 1'b0;
      redirect   = 1'b1;
    end else if (stall) begin
      // MEM0 and MEM hold; a bubble goes to WB so the held
      // instruction cannot commit twice.
      mem0_wr    = 1'b0;
      mem_wr     = 1'b0;
      wb_wr      = 1'b0;
      wb_flush   = 1'b1;
      ex_allowin = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || excp) begin
      mem0_valid <= 1'b0;
      mem_valid  <= 1'b0;
      wb_valid   <= 1'b0;
    end else if (stall) begin
      wb_valid   <= 1'b0;
    end else begin
      wb_valid   <= mem_valid;
      mem_valid  <= mem0_valid;
      mem0_valid <= ex_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      miss_stall_cnt <= '0;
    else if (stall && (miss_stall_cnt != '1))
      miss_stall_cnt <= miss_stall_cnt + CNT_W'(1);
  end

  assign busy = (state != IDLE);

endmodule
